// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss counter with prescaled one-second step, up/down mode,
// validated load and an EXPIRED state for countdown completion.
module bcd_time_counter #(
  parameter int TICK_DIV   = 1,
  parameter int HOURS_WRAP = 24
) (
  input  logic        clkout,
  input  logic        rst,
  input  logic        en,
  input  logic        dir,
  input  logic        load,
  input  logic [23:0] load_val,
  output logic [23:0] time_out,
  output logic        tick,
  output logic        day_wrap,
  output logic        expired,
  output logic        load_err
);

  typedef enum logic [1:0] {STOP, RUN, EXPIRED} state_e;

  localparam logic [15:0] PS_MAX = 16'(TICK_DIV - 1);
  localparam logic [3:0]  HT_MAX = 4'((HOURS_WRAP - 1) / 10);
  localparam logic [3:0]  HO_MAX = 4'((HOURS_WRAP - 1) % 10);
  localparam logic [7:0]  HW8    = 8'(HOURS_WRAP);

  state_e      state_q, state_d;
  logic [23:0] time_q, time_d;
  logic [15:0] ps_q, ps_d;
  logic        tick_q, tick_d;
  logic        wrap_q, wrap_d;
  logic        err_q, err_d;

  logic [23:0] inc_t, dec_t;
  logic [7:0]  hval;
  logic        valid;
  logic        zero;

  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd9) s0 = s0 + 4'd1;
    else begin
      s0 = 4'd0;
      if (s1 != 4'd5) s1 = s1 + 4'd1;
      else begin
        s1 = 4'd0;
        if (m0 != 4'd9) m0 = m0 + 4'd1;
        else begin
          m0 = 4'd0;
          if (m1 != 4'd5) m1 = m1 + 4'd1;
          else begin
            m1 = 4'd0;
            if (h1 == HT_MAX && h0 == HO_MAX) begin
              h1 = 4'd0;
              h0 = 4'd0;
            end else if (h0 == 4'd9) begin
              h0 = 4'd0;
              h1 = h1 + 4'd1;
            end else h0 = h0 + 4'd1;
          end
        end
      end
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  function automatic logic [23:0] bcd_dec(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd0) s0 = s0 - 4'd1;
    else begin
      s0 = 4'd9;
      if (s1 != 4'd0) s1 = s1 - 4'd1;
      else begin
        s1 = 4'd5;
        if (m0 != 4'd0) m0 = m0 - 4'd1;
        else begin
          m0 = 4'd9;
          if (m1 != 4'd0) m1 = m1 - 4'd1;
          else begin
            m1 = 4'd5;
            if (h1 == 4'd0 && h0 == 4'd0) begin
              h1 = HT_MAX;
              h0 = HO_MAX;
            end else if (h0 == 4'd0) begin
              h0 = 4'd9;
              h1 = h1 - 4'd1;
            end else h0 = h0 - 4'd1;
          end
        end
      end
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  always_comb begin
    hval  = 8'(load_val[23:20]) * 8'd10 + 8'(load_val[19:16]);
    valid = (load_val[15:12] <= 4'd5) && (load_val[7:4] <= 4'd5)
         && (hval < HW8);
    for (int i = 0; i < 6; i++)
      if (load_val[i*4 +: 4] > 4'd9) valid = 1'b0;
  end

  assign inc_t = bcd_inc(time_q);
  assign dec_t = bcd_dec(time_q);
  assign zero  = (time_q == 24'h0);

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    ps_d    = ps_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    // A rejected load freezes the whole counter for that cycle
    if (load && !valid) begin
      err_d = 1'b1;
    end else if (load) begin
      time_d  = load_val;
      ps_d    = 16'd0;
      state_d = en ? RUN : STOP;
    end else begin
      unique case (state_q)
        STOP: if (en) state_d = RUN;
        RUN: begin
          if (!en) state_d = STOP;
          else if (dir && zero) state_d = EXPIRED;
          else if (ps_q == PS_MAX) begin
            ps_d   = 16'd0;
            tick_d = 1'b1;
            if (dir) begin
              time_d = dec_t;
              if (dec_t == 24'h0) state_d = EXPIRED;
            end else begin
              time_d = inc_t;
              wrap_d = (inc_t == 24'h0);
            end
          end else ps_d = ps_q + 16'd1;
        end
        EXPIRED: if (!dir) state_d = en ? RUN : STOP;
        default: state_d = STOP;
      endcase
    end
  end

  always_ff @(posedge clkout or negedge rst) begin
    if (!rst) begin
      state_q <= STOP;
      time_q  <= 24'h0;
      ps_q    <= 16'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      ps_q    <= ps_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign time_out = time_q;
  assign tick     = tick_q;
  assign day_wrap = wrap_q;
  assign expired  = (state_q == EXPIRED);
  assign load_err = err_q;

endmodule
